// File: rtl/block_lock_ber_monitor.sv
// block_lock_ber_monitor
//   Receive-side block lock for a 64b/66b PCS. It acquires block lock from
//   sync headers and asks the block sync for a bit slip when alignment is bad.
//   After each slip it ignores a settle window of headers. While locked, it
//   also runs a hi-BER monitor and a saturating errored-header counter.
//
// Ports
//   i_clk        clock
//   i_reset_n    asynchronous active-low reset
//   i_hdr        sync header from block sync
//   i_hdr_valid  i_hdr is valid this cycle
//   i_err_clr    synchronous clear of o_err_cnt
//   o_slip       one-cycle slip request to block sync
//   o_block_lock block lock status
//   o_hi_ber     high bit-error-rate status
//   o_err_cnt    saturating count of invalid headers seen while locked
module block_lock_ber_monitor #(
  parameter int                   HDR_WIDTH     = 2,
  parameter logic [HDR_WIDTH-1:0] SYNC_DATA     = 2'b01,
  parameter logic [HDR_WIDTH-1:0] SYNC_CTRL     = 2'b10,
  parameter int                   LOCK_CNT      = 64,
  parameter int                   INVALID_MAX   = 16,
  parameter int                   SLIP_WAIT     = 32,
  parameter int                   BER_WINDOW    = 19531,
  parameter int                   BER_THRESH    = 16,
  parameter int                   ERR_CNT_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic [HDR_WIDTH-1:0]     i_hdr,
  input  logic                     i_hdr_valid,
  input  logic                     i_err_clr,
  output logic                     o_slip,
  output logic                     o_block_lock,
  output logic                     o_hi_ber,
  output logic [ERR_CNT_WIDTH-1:0] o_err_cnt
);

  // Each counter is sized to hold its terminal value, so none can overflow.
  localparam int SH_W  = $clog2(LOCK_CNT) + 1;
  localparam int INV_W = $clog2(INVALID_MAX) + 1;
  localparam int SET_W = $clog2(SLIP_WAIT) + 1;
  localparam int TMR_W = $clog2(BER_WINDOW) + 1;
  localparam int BER_W = $clog2(BER_THRESH) + 1;

  typedef enum logic [0:0] {
    ST_TEST   = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [SH_W-1:0]    sh_cnt, sh_next, sh_inc;
  logic [INV_W-1:0]   inv_cnt, inv_next, inv_inc;
  logic [SET_W-1:0]   settle_cnt, settle_next, settle_inc;
  logic               lock_next, slip_next;
  logic               sh_valid, hdr_err;
  logic [TMR_W-1:0]   ber_timer;
  logic [BER_W-1:0]   ber_cnt, ber_next;

  assign sh_valid = (i_hdr == SYNC_DATA) || (i_hdr == SYNC_CTRL);
  // Only headers tested in TEST count as errors. Headers seen during the
  // settle window come from a misaligned stream and are ignored.
  assign hdr_err  = i_hdr_valid && (state == ST_TEST) && !sh_valid;

  // Lock FSM state, counters and the registered lock/slip outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= ST_TEST;
      sh_cnt       <= '0;
      inv_cnt      <= '0;
      settle_cnt   <= '0;
      o_block_lock <= 1'b0;
      o_slip       <= 1'b0;
    end else begin
      state        <= state_next;
      sh_cnt       <= sh_next;
      inv_cnt      <= inv_next;
      settle_cnt   <= settle_next;
      o_block_lock <= lock_next;
      o_slip       <= slip_next;
    end
  end

  // Next-state logic. A slip always moves the FSM to SETTLE for at least one
  // cycle, so slips can never be requested on back-to-back cycles. When the
  // INVALID_MAX-th error is also the LOCK_CNT-th header, the invalid check is
  // evaluated first, so the lock drop wins.
  always_comb begin
    state_next  = state;
    sh_next     = sh_cnt;
    inv_next    = inv_cnt;
    settle_next = settle_cnt;
    lock_next   = o_block_lock;
    slip_next   = 1'b0;
    sh_inc      = sh_cnt + SH_W'(1);
    inv_inc     = sh_valid ? inv_cnt : inv_cnt + INV_W'(1);
    settle_inc  = settle_cnt + SET_W'(1);
    case (state)
      ST_TEST: begin
        if (i_hdr_valid) begin
          if (!o_block_lock) begin
            if (!sh_valid) begin
              slip_next  = 1'b1;
              sh_next    = '0;
              inv_next   = '0;
              state_next = ST_SETTLE;
            end else if (sh_inc == SH_W'(LOCK_CNT)) begin
              lock_next = 1'b1;
              sh_next   = '0;
              inv_next  = '0;
            end else begin
              sh_next = sh_inc;
            end
          end else begin
            if (inv_inc == INV_W'(INVALID_MAX)) begin
              lock_next  = 1'b0;
              slip_next  = 1'b1;
              sh_next    = '0;
              inv_next   = '0;
              state_next = ST_SETTLE;
            end else if (sh_inc == SH_W'(LOCK_CNT)) begin
              sh_next  = '0;
              inv_next = '0;
            end else begin
              sh_next  = sh_inc;
              inv_next = inv_inc;
            end
          end
        end
      end
      ST_SETTLE: begin
        if (SLIP_WAIT == 0) begin
          state_next  = ST_TEST;
          settle_next = '0;
        end else if (i_hdr_valid) begin
          if (settle_inc == SET_W'(SLIP_WAIT)) begin
            state_next  = ST_TEST;
            settle_next = '0;
          end else begin
            settle_next = settle_inc;
          end
        end
      end
      default: begin
        state_next = ST_TEST;
      end
    endcase
  end

  // The BER count saturates at the threshold.
  always_comb begin
    ber_next = ber_cnt;
    if (hdr_err && (ber_cnt != BER_W'(BER_THRESH))) begin
      ber_next = ber_cnt + BER_W'(1);
    end
  end

  // The hi-BER monitor runs only while lock is visible and is held. If lock is
  // absent, or drops this cycle, the monitor is cleared. This keeps o_hi_ber
  // low whenever o_block_lock is low. At the terminal timer cycle, the
  // current header still counts toward the window verdict.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ber_timer <= '0;
      ber_cnt   <= '0;
      o_hi_ber  <= 1'b0;
    end else if (!o_block_lock || !lock_next) begin
      ber_timer <= '0;
      ber_cnt   <= '0;
      o_hi_ber  <= 1'b0;
    end else if (ber_timer == TMR_W'(BER_WINDOW - 1)) begin
      ber_timer <= '0;
      ber_cnt   <= '0;
      o_hi_ber  <= (ber_next == BER_W'(BER_THRESH));
    end else begin
      ber_timer <= ber_timer + TMR_W'(1);
      ber_cnt   <= ber_next;
      if (ber_next == BER_W'(BER_THRESH)) begin
        o_hi_ber <= 1'b1;
      end
    end
  end

  // Status error counter. It saturates at all-ones and never wraps. A clear
  // takes priority over a simultaneous increment.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_err_cnt <= '0;
    end else if (i_err_clr) begin
      o_err_cnt <= '0;
    end else if (hdr_err && o_block_lock && (o_err_cnt != '1)) begin
      o_err_cnt <= o_err_cnt + ERR_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_block_lock_ber_monitor.sv
// tb_block_lock_ber_monitor
//   Directed bench for block_lock_ber_monitor. Both instances share every
//   input. dut_a uses the default parameters. dut_b shortens the BER window
//   to 200 cycles and narrows the error counter to 4 bits. The lock behaviour
//   of the two instances is identical, so each check looks at whichever
//   instance shows the feature best.
module tb_block_lock_ber_monitor;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [1:0]  i_hdr;
  logic        i_hdr_valid;
  logic        i_err_clr;

  logic        o_slip_a, o_block_lock_a, o_hi_ber_a;
  logic [15:0] o_err_cnt_a;
  logic        o_slip_b, o_block_lock_b, o_hi_ber_b;
  logic [3:0]  o_err_cnt_b;

  int checks     = 0;
  int failures   = 0;
  int slip_count = 0;
  int slip_consec = 0;
  logic prev_slip = 1'b0;
  logic hdr_toggle = 1'b0;

  always #5 i_clk = ~i_clk;

  block_lock_ber_monitor dut_a (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_hdr        (i_hdr),
    .i_hdr_valid  (i_hdr_valid),
    .i_err_clr    (i_err_clr),
    .o_slip       (o_slip_a),
    .o_block_lock (o_block_lock_a),
    .o_hi_ber     (o_hi_ber_a),
    .o_err_cnt    (o_err_cnt_a)
  );

  block_lock_ber_monitor #(
    .BER_WINDOW    (200),
    .ERR_CNT_WIDTH (4)
  ) dut_b (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_hdr        (i_hdr),
    .i_hdr_valid  (i_hdr_valid),
    .i_err_clr    (i_err_clr),
    .o_slip       (o_slip_b),
    .o_block_lock (o_block_lock_b),
    .o_hi_ber     (o_hi_ber_b),
    .o_err_cnt    (o_err_cnt_b)
  );

  // Counts one comparison and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Drives one cycle of input and waits a full clock. On return, the outputs
  // show the effect of this header. Slip pulses are also tallied here.
  task automatic applyStimulus(input logic [1:0] hdr, input logic vld,
                               input logic clr);
    i_hdr       = hdr;
    i_hdr_valid = vld;
    i_err_clr   = clr;
    @(negedge i_clk);
    if (o_slip_a) begin
      slip_count++;
      if (prev_slip) slip_consec++;
    end
    prev_slip = o_slip_a;
  endtask

  task automatic sendValid(input int n);
    for (int i = 0; i < n; i++) begin
      hdr_toggle = ~hdr_toggle;
      applyStimulus(hdr_toggle ? 2'b01 : 2'b10, 1'b1, 1'b0);
    end
  endtask

  task automatic sendInvalid(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus((i % 2 == 0) ? 2'b11 : 2'b00, 1'b1, 1'b0);
    end
  endtask

  // Asserts reset between clock edges. It checks that every output has
  // already cleared, then releases reset on a falling edge.
  task automatic asyncReset(input string tag);
    #2 i_reset_n = 1'b0;
    #1;
    checkOutput({tag, "_lock_a"}, 32'(o_block_lock_a), 32'd0);
    checkOutput({tag, "_slip_a"}, 32'(o_slip_a), 32'd0);
    checkOutput({tag, "_hiber_a"}, 32'(o_hi_ber_a), 32'd0);
    checkOutput({tag, "_err_a"}, 32'(o_err_cnt_a), 32'd0);
    checkOutput({tag, "_lock_b"}, 32'(o_block_lock_b), 32'd0);
    checkOutput({tag, "_err_b"}, 32'(o_err_cnt_b), 32'd0);
    i_hdr_valid = 1'b0;
    i_err_clr   = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    prev_slip = 1'b0;
  endtask

  initial begin
    i_reset_n   = 1'b0;
    i_hdr       = 2'b00;
    i_hdr_valid = 1'b0;
    i_err_clr   = 1'b0;
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;

    // Reset values, then acquire lock with 64 valid headers.
    checkOutput("rst_lock", 32'(o_block_lock_a), 32'd0);
    checkOutput("rst_slip", 32'(o_slip_a), 32'd0);
    checkOutput("rst_hiber", 32'(o_hi_ber_a), 32'd0);
    checkOutput("rst_err", 32'(o_err_cnt_a), 32'd0);
    sendValid(63);
    checkOutput("lock_at63", 32'(o_block_lock_a), 32'd0);
    sendValid(1);
    checkOutput("lock_at64", 32'(o_block_lock_a), 32'd1);
    checkOutput("lock_noslip", 32'(slip_count), 32'd0);

    // Async reset in the middle of a lock window.
    sendValid(10);
    checkOutput("midwin_pre_lock", 32'(o_block_lock_a), 32'd1);
    asyncReset("midwin");

    // Invalid header while unlocked, then the settle window, then relock.
    sendValid(9);
    applyStimulus(2'b11, 1'b1, 1'b0);
    checkOutput("unl_slip", 32'(o_slip_a), 32'd1);
    checkOutput("unl_slip_b", 32'(o_slip_b), 32'd1);
    sendInvalid(1);
    checkOutput("unl_slip_1cyc", 32'(o_slip_a), 32'd0);
    sendInvalid(31);
    checkOutput("settle_noslip", 32'(slip_count), 32'd1);
    sendValid(63);
    checkOutput("relock_at63", 32'(o_block_lock_a), 32'd0);
    sendValid(1);
    checkOutput("relock_at64", 32'(o_block_lock_a), 32'd1);

    // Window 1 has 15 invalid headers, so lock holds. Window 2 has 16 invalid
    // headers, so lock drops.
    sendInvalid(15);
    sendValid(49);
    checkOutput("w15_lock", 32'(o_block_lock_a), 32'd1);
    checkOutput("w15_err", 32'(o_err_cnt_a), 32'd15);
    sendInvalid(1);
    checkOutput("w16_hiber_a", 32'(o_hi_ber_a), 32'd1);
    sendInvalid(14);
    checkOutput("w16_lock_at15", 32'(o_block_lock_a), 32'd1);
    sendInvalid(1);
    checkOutput("w16_lock_drop", 32'(o_block_lock_a), 32'd0);
    checkOutput("w16_slip", 32'(o_slip_a), 32'd1);
    checkOutput("w16_hiber_clr", 32'(o_hi_ber_a), 32'd0);
    checkOutput("w16_err_a", 32'(o_err_cnt_a), 32'd31);
    checkOutput("w16_err_b_sat", 32'(o_err_cnt_b), 32'd15);

    // Async reset while the slip pulse is high, then reacquire lock.
    asyncReset("midslip");
    sendValid(63);
    checkOutput("reacq_at63", 32'(o_block_lock_a), 32'd0);
    sendValid(1);
    checkOutput("reacq_at64", 32'(o_block_lock_b), 32'd1);

    // Hi-BER: 16 errors spread over three lock windows. dut_b uses a
    // 200-cycle BER window covering headers 1..200, then 201..400.
    sendInvalid(6);
    sendValid(58);
    sendInvalid(6);
    sendValid(58);
    sendInvalid(3);
    checkOutput("ber_at15_b", 32'(o_hi_ber_b), 32'd0);
    sendInvalid(1);
    checkOutput("ber_at16_b", 32'(o_hi_ber_b), 32'd1);
    checkOutput("ber_at16_a", 32'(o_hi_ber_a), 32'd1);
    checkOutput("ber_lock_held", 32'(o_block_lock_b), 32'd1);
    sendValid(68);
    checkOutput("ber_wrap1_b", 32'(o_hi_ber_b), 32'd1);
    sendValid(199);
    checkOutput("ber_pre_wrap2_b", 32'(o_hi_ber_b), 32'd1);
    sendValid(1);
    checkOutput("ber_wrap2_b", 32'(o_hi_ber_b), 32'd0);
    checkOutput("ber_long_win_a", 32'(o_hi_ber_a), 32'd1);
    checkOutput("ber_err_a", 32'(o_err_cnt_a), 32'd16);

    // Error counter saturation, then clear colliding with an increment.
    sendInvalid(4);
    checkOutput("err20_a", 32'(o_err_cnt_a), 32'd20);
    checkOutput("err20_b_sat", 32'(o_err_cnt_b), 32'd15);
    applyStimulus(2'b11, 1'b1, 1'b1);
    checkOutput("errclr_a", 32'(o_err_cnt_a), 32'd0);
    checkOutput("errclr_b", 32'(o_err_cnt_b), 32'd0);
    sendInvalid(1);
    checkOutput("err_after_clr_b", 32'(o_err_cnt_b), 32'd1);

    // Boundary: the 16th error lands on the 64th header, and the drop wins.
    sendValid(42);
    sendValid(48);
    sendInvalid(15);
    checkOutput("bnd_lock_at63", 32'(o_block_lock_a), 32'd1);
    checkOutput("bnd_noslip_at63", 32'(o_slip_a), 32'd0);
    sendInvalid(1);
    checkOutput("bnd_lock_drop", 32'(o_block_lock_a), 32'd0);
    checkOutput("bnd_slip", 32'(o_slip_a), 32'd1);

    checkOutput("slip_total", 32'(slip_count), 32'd3);
    checkOutput("slip_consec", 32'(slip_consec), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
